// File: rtl/fp_arb_pkg.sv
// Shared types for the fp_addsub_arbiter slice: word width, FSM encoding and
// the requester tag that travels alongside each operation in the adder.
package fp_arb_pkg;

    localparam int unsigned FP_W     = 32;
    // Tag id field is sized for up to 256 requesters; the top narrows it to ID_W.
    localparam int unsigned TAG_ID_W = 8;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                vld;
        logic [TAG_ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/fp_addsub_arbiter_rr.sv
// rr_arbiter: one-hot grant over N requests.
// Default build: round-robin, search starts at an internal pointer that moves
// to (winner+1) mod N whenever 'advance' is high.
// With FP_ARB_FIXED_PRIO_EN defined: lowest index wins and no pointer exists.
module rr_arbiter #(
    parameter  int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

`ifdef FP_ARB_FIXED_PRIO_EN
    // Clock, reset and advance have no effect without a pointer.
    logic unused_inputs;
    assign unused_inputs = ^{clk, reset_n, advance};

    // Lowest-index valid request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;
    logic             found;
    int unsigned      cand;

    // Circular search starting at the pointer; first valid request wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (!found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = IDX_W'(cand);
            end
        end
    end

    // Pointer moves just past the winner on a transfer, wrapping at N-1.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            ptr_d = (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

endmodule

// File: rtl/fp_addsub_arbiter.sv
// fp_addsub_arbiter: shares one pipelined FP adder/subtractor between
// NUM_REQ requesters. Operations are issued into registered add_* outputs,
// a {vld,id} tag rides a shift pipeline matched to the adder latency, and
// the adder result is returned tagged with its owner.
// Optional build macro: FP_ARB_FIXED_PRIO_EN (fixed priority instead of RR).
//
// Handshake: requester i transfers on a rising edge where req_valid[i] and
// req_ready[i] are both high; req_ready is combinational from req_valid,
// hold, the FSM state and the arbiter, and is never high outside RUN.
// Responses are single-cycle pulses with no backpressure.
module fp_addsub_arbiter
    import fp_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ     = 4,
    parameter  int unsigned ADD_LATENCY = 2,
    localparam int unsigned ID_W        = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_a,
    input  logic [NUM_REQ*FP_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]      req_sub,
    input  logic                    hold,
    output logic                    idle,
    output logic [FP_W-1:0]         add_A,
    output logic [FP_W-1:0]         add_B,
    output logic                    add_IsSub,
    input  logic [FP_W-1:0]         add_result,
    output logic                    resp_valid,
    output logic [ID_W-1:0]         resp_id,
    output logic [FP_W-1:0]         resp_result,
    output logic [1:0]              dbg_state
);

    arb_state_t state_q, state_d;

    logic [FP_W-1:0] add_a_q, add_a_d;
    logic [FP_W-1:0] add_b_q, add_b_d;
    logic            add_is_sub_q, add_is_sub_d;

    tag_t tag_q [ADD_LATENCY+1];
    tag_t tag_d [ADD_LATENCY+1];

    logic            resp_valid_q, resp_valid_d;
    logic [ID_W-1:0] resp_id_q, resp_id_d;
    logic [FP_W-1:0] resp_result_q, resp_result_d;

    logic               accept;
    logic               transfer;
    logic               busy;
    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] arb_gnt;
    logic [ID_W-1:0]    gnt_idx;

    // Only RUN accepts; hold kills the grant in the same cycle, and reset
    // forces req_ready low while asserted.
    assign accept   = (state_q == RUN) && !hold && reset_n;
    assign arb_req  = req_valid & {NUM_REQ{accept}};
    assign transfer = |arb_gnt;

    rr_arbiter #(
        .N (NUM_REQ)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (arb_req),
        .advance (transfer),
        .gnt     (arb_gnt),
        .gnt_idx (gnt_idx)
    );

    // Any valid tag means an operation is still inside the adder.
    always_comb begin
        busy = 1'b0;
        for (int k = 0; k <= int'(ADD_LATENCY); k++) begin
            busy = busy | tag_q[k].vld;
        end
    end

    // RUN/DRAIN/HALT next state: drain until no tag is in flight, then halt.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (hold) state_d = DRAIN;
            DRAIN:   if (!hold) state_d = RUN;
                     else if (!busy) state_d = HALT;
            HALT:    if (!hold) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Operand mux into the adder registers, tag shift and response capture.
    always_comb begin
        add_a_d      = add_a_q;
        add_b_d      = add_b_q;
        add_is_sub_d = add_is_sub_q;
        if (transfer) begin
            add_a_d      = req_a[FP_W*gnt_idx +: FP_W];
            add_b_d      = req_b[FP_W*gnt_idx +: FP_W];
            add_is_sub_d = req_sub[gnt_idx];
        end
        tag_d[0].vld = transfer;
        tag_d[0].id  = TAG_ID_W'(gnt_idx);
        for (int k = 1; k <= int'(ADD_LATENCY); k++) begin
            tag_d[k] = tag_q[k-1];
        end
        resp_valid_d  = tag_q[ADD_LATENCY].vld;
        resp_id_d     = tag_q[ADD_LATENCY].id[ID_W-1:0];
        resp_result_d = tag_q[ADD_LATENCY].vld ? add_result : resp_result_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            add_a_q       <= '0;
            add_b_q       <= '0;
            add_is_sub_q  <= 1'b0;
            for (int k = 0; k <= int'(ADD_LATENCY); k++) begin
                tag_q[k] <= '0;
            end
            resp_valid_q  <= 1'b0;
            resp_id_q     <= '0;
            resp_result_q <= '0;
        end else begin
            add_a_q       <= add_a_d;
            add_b_q       <= add_b_d;
            add_is_sub_q  <= add_is_sub_d;
            for (int k = 0; k <= int'(ADD_LATENCY); k++) begin
                tag_q[k] <= tag_d[k];
            end
            resp_valid_q  <= resp_valid_d;
            resp_id_q     <= resp_id_d;
            resp_result_q <= resp_result_d;
        end
    end

    assign req_ready   = arb_gnt;
    assign idle        = !busy && !transfer;
    assign add_A       = add_a_q;
    assign add_B       = add_b_q;
    assign add_IsSub   = add_is_sub_q;
    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_fp_addsub_arbiter.sv
// Bench for fp_addsub_arbiter with a behavioural pipelined FP adder beside it.
// Honours FP_ARB_FIXED_PRIO_EN in its grant model.
module tb_fp_addsub_arbiter;

    localparam int N  = 4;
    localparam int L  = 2;
    localparam int EW = 66;  // {due[31:0], id[1:0], result[31:0]}

    logic            clk;
    logic            reset_n;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_a;
    logic [N*32-1:0] req_b;
    logic [N-1:0]    req_sub;
    logic            hold;
    logic            idle;
    logic [31:0]     add_A;
    logic [31:0]     add_B;
    logic            add_IsSub;
    logic [31:0]     add_result;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [31:0]     resp_result;
    logic [1:0]      dbg_state;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ptr_m    = 0;
    int mode_m   = 0;  // 0 RUN, 1 DRAIN, 2 HALT
    logic [EW-1:0] exp_q[$];
    logic [31:0]   last_res;
    logic [1:0]    last_id;
    int            gnt3_cnt;

    fp_addsub_arbiter #(.NUM_REQ(N), .ADD_LATENCY(L)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_sub     (req_sub),
        .hold        (hold),
        .idle        (idle),
        .add_A       (add_A),
        .add_B       (add_B),
        .add_IsSub   (add_IsSub),
        .add_result  (add_result),
        .resp_valid  (resp_valid),
        .resp_id     (resp_id),
        .resp_result (resp_result),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- float helpers (normal numbers and zero) ----------------
    function automatic logic [63:0] f2d(input logic [31:0] f);
        int e;
        if (f[30:0] == 31'b0) return {f[31], 63'b0};
        e = int'(f[30:23]) - 127 + 1023;
        return {f[31], e[10:0], f[22:0], 29'b0};
    endfunction

    function automatic logic [31:0] d2f(input logic [63:0] d);
        int          e;
        logic [23:0] mr;
        logic [28:0] rem;
        e = int'(d[62:52]);
        if (e == 0) return {d[63], 31'b0};
        e   = e - 1023 + 127;
        mr  = {1'b0, d[51:29]};
        rem = d[28:0];
        if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && mr[0])) mr = mr + 24'd1;
        if (mr[23]) begin
            mr = '0;
            e  = e + 1;
        end
        return {d[63], e[7:0], mr[22:0]};
    endfunction

    function automatic logic [31:0] itof(input int v);
        return d2f($realtobits(real'(v)));
    endfunction

    function automatic logic [31:0] fp_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
        real ra, rb, r;
        ra = $bitstoreal(f2d(a));
        rb = $bitstoreal(f2d(b));
        r  = s ? (ra - rb) : (ra + rb);
        return d2f($realtobits(r));
    endfunction

    // ---------------- external adder model, L register stages ----------------
    logic [31:0] add_pipe [L];
    always @(posedge clk) begin
        add_pipe[0] <= fp_ref(add_A, add_B, add_IsSub);
        for (int k = 1; k < L; k++) add_pipe[k] <= add_pipe[k-1];
    end
    assign add_result = add_pipe[L-1];

    // ---------------- reference grant rule ----------------
    function automatic int model_grant(input logic [N-1:0] v, input int p);
`ifdef FP_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
`else
        for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
`endif
        return -1;
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: check grant/idle before the edge, update the model on the
    // edge, check the response and state after it.
    task automatic tick(input string tag);
        int            g;
        logic [N-1:0]  exp_rdy;
        bit            busy;
        logic [EW-1:0] e;
        g = (mode_m == 0 && !hold) ? model_grant(req_valid, ptr_m) : -1;
        exp_rdy = (g >= 0) ? N'(1 << g) : '0;
        #5;
        chk({tag, ".ready"}, 64'(req_ready), 64'(exp_rdy));
        chk({tag, ".idle"}, 64'(idle), 64'(exp_q.size() == 0 && g < 0));
        if (req_ready[3]) gnt3_cnt++;
        busy = (exp_q.size() != 0);
        @(posedge clk);
        cyc++;
        if (g >= 0) begin
            exp_q.push_back({32'(cyc + L + 1), 2'(g),
                             fp_ref(req_a[32*g +: 32], req_b[32*g +: 32], req_sub[g])});
            ptr_m = (g + 1) % N;
        end
        case (mode_m)
            0: if (hold) mode_m = 1;
            1: if (!hold) mode_m = 0; else if (!busy) mode_m = 2;
            default: if (!hold) mode_m = 0;
        endcase
        @(negedge clk);
        if (exp_q.size() > 0 && exp_q[0][65:34] == 32'(cyc)) begin
            e = exp_q.pop_front();
            chk({tag, ".resp_valid"}, 64'(resp_valid), 64'(1));
            chk({tag, ".resp_id"}, 64'(resp_id), 64'(e[33:32]));
            chk({tag, ".resp_result"}, 64'(resp_result), 64'(e[31:0]));
            last_res = resp_result;
            last_id  = resp_id;
        end else begin
            chk({tag, ".resp_quiet"}, 64'(resp_valid), 64'(0));
        end
        chk({tag, ".state"}, 64'(dbg_state), 64'(mode_m));
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".req_ready"}, 64'(req_ready), 64'(0));
        chk({tag, ".add_A"}, 64'(add_A), 64'(0));
        chk({tag, ".add_B"}, 64'(add_B), 64'(0));
        chk({tag, ".add_IsSub"}, 64'(add_IsSub), 64'(0));
        chk({tag, ".resp_valid"}, 64'(resp_valid), 64'(0));
        chk({tag, ".resp_id"}, 64'(resp_id), 64'(0));
        chk({tag, ".resp_result"}, 64'(resp_result), 64'(0));
        chk({tag, ".idle"}, 64'(idle), 64'(1));
        chk({tag, ".state"}, 64'(dbg_state), 64'(0));
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic s);
        req_a[32*i +: 32] = a;
        req_b[32*i +: 32] = b;
        req_sub[i]        = s;
    endtask

    // ---------------- directed and random sequence ----------------
    initial begin
        reset_n   = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        req_sub   = '0;
        hold      = 1'b0;
        gnt3_cnt  = 0;
        last_res  = '0;
        last_id   = '0;

        // Reset values, with every requester valid during reset.
        #5;
        check_reset_values("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n   = 1'b1;
        req_valid = '0;

        // 1: single add on requester 0.
        set_req(0, 32'hC04CCCCD, 32'h3F333333, 1'b0);
        req_valid = 4'b0001;
        tick("add0");
        req_valid = '0;
        repeat (L + 1) tick("add0_wait");
        chk("add0.result_const", 64'(last_res), 64'(32'hC0200000));
        chk("add0.id_const", 64'(last_id), 64'(0));

        // 2: single subtract on requester 2.
        set_req(2, 32'h3F800000, 32'h3F000000, 1'b1);
        req_valid = 4'b0100;
        tick("sub2");
        req_valid = '0;
        repeat (L + 1) tick("sub2_wait");
        chk("sub2.result_const", 64'(last_res), 64'(32'h3F000000));
        chk("sub2.id_const", 64'(last_id), 64'(2));

        // 3: all requesters valid, back-to-back issue.
        for (int i = 0; i < N; i++) set_req(i, 32'h40000000, 32'h40000000, 1'b0);
        req_valid = '1;
        repeat (10) tick("all4");
        chk("all4.result_const", 64'(last_res), 64'(32'h40800000));

        // 4: hold with operations in flight, then resume.
        hold = 1'b1;
        repeat (6) tick("hold_drain");
        chk("hold.halt_idle", 64'(idle), 64'(1));
        hold = 1'b0;
        repeat (4) tick("hold_resume");
        // Short hold released mid-drain.
        hold = 1'b1;
        tick("drain_short");
        hold = 1'b0;
        repeat (3) tick("drain_back");
        req_valid = '0;
        repeat (L + 2) tick("flush1");

        // 5: reset with two operations in flight.
        for (int i = 0; i < N; i++) set_req(i, itof(i + 1), itof(10 * i), 1'b1);
        req_valid = 4'b0011;
        repeat (2) tick("pre_reset");
        req_valid = '0;
        #3;
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        exp_q.delete();
        ptr_m  = 0;
        mode_m = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (L + 3) tick("post_reset");

        // 6: requesters 0 and 3 continuously valid.
        set_req(0, itof(5), itof(6), 1'b0);
        set_req(3, itof(7), itof(8), 1'b1);
        req_valid = 4'b1001;
        gnt3_cnt  = 0;
        repeat (6) tick("prio03");
`ifdef FP_ARB_FIXED_PRIO_EN
        chk("prio03.gnt3_count", 64'(gnt3_cnt), 64'(0));
`else
        chk("prio03.gnt3_count", 64'(gnt3_cnt), 64'(3));
`endif
        req_valid = '0;
        repeat (L + 2) tick("flush2");

        // Random traffic with occasional hold toggles.
        for (int c = 0; c < 200; c++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                set_req(i, itof($urandom_range(0, 2000) - 1000),
                        itof($urandom_range(0, 2000) - 1000), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 19) == 0) hold = ~hold;
            tick("rand");
        end
        hold      = 1'b0;
        req_valid = '0;
        repeat (L + 4) tick("final_flush");
        chk("final.queue_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
